// File: rtl/multi_fold_coincidence.sv
// multi_fold_coincidence: N-channel coincidence detector.
// A rising edge on a channel arms it for window+1 cycles. A coincidence fires
// when at least min_fold masked channels are armed together. Each fire:
// - emits a one-cycle pulse,
// - clears all windows,
// - starts dead_time cycles of dead time,
// - bumps a saturating event counter.
// Optional build macro MULTI_FOLD_SINGLES_EN adds per-channel saturating edge
// counters on singles_count (channel i in bits [i*CNT_W +: CNT_W]).
// Handshake: no valid/ready. Inputs are sampled every clk; coinc_pulse is a
// plain one-cycle strobe; busy is high for exactly dead_time cycles after it.
module multi_fold_coincidence #(
  parameter int N_CH  = 4,
  parameter int WIN_W = 4,
  parameter int DT_W  = 8,
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             ch_in,
  input  logic [N_CH-1:0]             ch_mask,
  input  logic [$clog2(N_CH+1)-1:0]   min_fold,
  input  logic [WIN_W-1:0]            window,
  input  logic [DT_W-1:0]             dead_time,
  input  logic                        cnt_clr,
  output logic                        coinc_pulse,
  output logic                        busy,
  output logic [CNT_W-1:0]            coinc_count
`ifdef MULTI_FOLD_SINGLES_EN
  ,
  output logic [N_CH*CNT_W-1:0]       singles_count
`endif
);

  localparam int FW = $clog2(N_CH+1);

  typedef enum logic {IDLE = 1'b0, DEAD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_CH-1:0]    in_q, in_qq;
  logic [N_CH-1:0]    rise;
  logic [N_CH-1:0]    armed;
  logic [FW-1:0]      fold;
  logic               cond;
  logic               fire;
  logic [WIN_W-1:0]   win_cnt [N_CH];
  logic [DT_W-1:0]    dt_cnt;

  // Input history for edge detection; keeps tracking during dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= ch_in;
      in_qq <= in_q;
    end
  end

  // Edge, armed set, fold count and FSM next state.
  always_comb begin
    rise    = in_q & ~in_qq;
    armed   = '0;
    fold    = '0;
    fire    = 1'b0;
    state_d = state_q;
    for (int i = 0; i < N_CH; i++) begin
      armed[i] = rise[i] | (win_cnt[i] != '0);
      fold     = fold + FW'(armed[i] & ch_mask[i]);
    end
    cond = (min_fold != '0) && (fold >= min_fold);
    case (state_q)
      IDLE: begin
        if (cond) begin
          fire = 1'b1;
          if (dead_time != '0) state_d = DEAD;
        end
      end
      DEAD: begin
        if (dt_cnt <= DT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Per-channel windows: load on edge, count down, cleared by a fire or dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) win_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (state_q == DEAD || fire)  win_cnt[i] <= '0;
        else if (rise[i])             win_cnt[i] <= window;
        else if (win_cnt[i] != '0)    win_cnt[i] <= win_cnt[i] - WIN_W'(1);
      end
    end
  end

  // Dead-time counter: captured at fire, so later dead_time changes do not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    dt_cnt <= '0;
    else if (fire)              dt_cnt <= dead_time;
    else if (state_q == DEAD)   dt_cnt <= dt_cnt - DT_W'(1);
  end

  // Pulse and saturating coincidence counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coinc_pulse <= 1'b0;
      coinc_count <= '0;
    end else begin
      coinc_pulse <= fire;
      if (cnt_clr)                         coinc_count <= '0;
      else if (fire && coinc_count != '1)  coinc_count <= coinc_count + CNT_W'(1);
    end
  end

  assign busy = (state_q == DEAD);

`ifdef MULTI_FOLD_SINGLES_EN
  logic [CNT_W-1:0] singles_q [N_CH];

  // Per-channel edge counters, independent of mask, state and dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) singles_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr)                          singles_q[i] <= '0;
        else if (rise[i] && singles_q[i] != '1) singles_q[i] <= singles_q[i] + CNT_W'(1);
      end
    end
  end

  // Flatten per-channel counters onto the output bus.
  always_comb begin
    singles_count = '0;
    for (int i = 0; i < N_CH; i++) singles_count[i*CNT_W +: CNT_W] = singles_q[i];
  end
`endif

endmodule

// File: tb/tb_multi_fold_coincidence.sv
// Bench for multi_fold_coincidence: directed phases plus randomized steps,
// checked against a cycle-numbered reference model (window/dead-time end times).
module tb_multi_fold_coincidence;

  localparam int N_CH  = 4;
  localparam int WIN_W = 4;
  localparam int DT_W  = 8;
  localparam int CNT_W = 4;
  localparam int FW    = $clog2(N_CH+1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   ch_in;
  logic [N_CH-1:0]   ch_mask;
  logic [FW-1:0]     min_fold;
  logic [WIN_W-1:0]  window;
  logic [DT_W-1:0]   dead_time;
  logic              cnt_clr;
  logic              coinc_pulse;
  logic              busy;
  logic [CNT_W-1:0]  coinc_count;
`ifdef MULTI_FOLD_SINGLES_EN
  logic [N_CH*CNT_W-1:0] singles_count;
`endif

  multi_fold_coincidence #(
    .N_CH(N_CH), .WIN_W(WIN_W), .DT_W(DT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_mask(ch_mask),
    .min_fold(min_fold), .window(window), .dead_time(dead_time),
    .cnt_clr(cnt_clr), .coinc_pulse(coinc_pulse), .busy(busy),
    .coinc_count(coinc_count)
`ifdef MULTI_FOLD_SINGLES_EN
    , .singles_count(singles_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int phase_pulses, phase_busy;

  // Reference model state, in absolute cycle numbers.
  int              cyc;
  int              dead_end;
  int              arm_end [N_CH];
  logic [N_CH-1:0] h1, h2;
  int              m_count;
  int              m_sing [N_CH];
  logic            exp_pulse, exp_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0; dead_end = -1; m_count = 0;
    for (int i = 0; i < N_CH; i++) begin
      arm_end[i] = -1;
      m_sing[i] = 0;
    end
  endtask

  // Evaluates the cycle about to end using the current (live) inputs.
  task automatic model_eval();
    logic [N_CH-1:0] e, armed;
    int  nf;
    bit  idle, fire;
    e    = h1 & ~h2;
    idle = (cyc > dead_end);
    for (int i = 0; i < N_CH; i++) armed[i] = e[i] || (idle && cyc <= arm_end[i]);
    nf   = $countones(armed & ch_mask);
    fire = idle && (min_fold != 0) && (nf >= int'(min_fold));
    if (fire) begin
      for (int i = 0; i < N_CH; i++) arm_end[i] = -1;
      if (dead_time != 0) dead_end = cyc + int'(dead_time);
    end else if (idle) begin
      for (int i = 0; i < N_CH; i++) if (e[i]) arm_end[i] = cyc + int'(window);
    end
    if (cnt_clr) m_count = 0;
    else if (fire && m_count < CMAX) m_count++;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_clr) m_sing[i] = 0;
      else if (e[i] && m_sing[i] < CMAX) m_sing[i]++;
    end
    exp_pulse = fire;
    cyc++;
    exp_busy = (cyc <= dead_end);
  endtask

  // One clock: model, edge, sample at +1, compare.
  task automatic step();
    model_eval();
    @(posedge clk);
    h2 = h1;
    h1 = ch_in;
    #1;
    check("coinc_pulse", coinc_pulse, exp_pulse);
    check("busy", busy, exp_busy);
    check("coinc_count", coinc_count, m_count);
`ifdef MULTI_FOLD_SINGLES_EN
    for (int i = 0; i < N_CH; i++)
      check("singles_count", singles_count[i*CNT_W +: CNT_W], m_sing[i]);
`endif
    if (coinc_pulse) phase_pulses++;
    if (busy) phase_busy++;
  endtask

  task automatic drive(input logic [N_CH-1:0] v);
    ch_in = v;
    step();
  endtask

  task automatic idle_steps(input int n);
    ch_in = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_cfg(input logic [N_CH-1:0] m, input int f, input int w, input int d);
    ch_mask = m; min_fold = FW'(f); window = WIN_W'(w); dead_time = DT_W'(d);
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1; ch_in = '0; step(); cnt_clr = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1; ch_in = '0; cnt_clr = 1'b0; cyc = 0;
    set_cfg(4'b0111, 3, 2, 5);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pulse", coinc_pulse, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_count", coinc_count, 0);
    rst = 1'b0;
    idle_steps(3);

    // Basic three-fold fire with staggered edges.
    phase_pulses = 0; phase_busy = 0;
    drive(4'b0001); drive(4'b0010); drive(4'b0100); idle_steps(8);
    check("basic_pulses", phase_pulses, 1);
    check("basic_busy_cycles", phase_busy, 5);
    check("basic_count", coinc_count, 1);

    // Window expiry: ch2 edge one cycle too late.
    phase_pulses = 0;
    drive(4'b0001); drive(4'b0010); drive(4'b0000); drive(4'b0100); idle_steps(6);
    check("expiry_pulses", phase_pulses, 0);
    check("expiry_count", coinc_count, 1);

    // Dead time: a triple during DEAD is ignored, one after it fires.
    clear_counts();
    phase_pulses = 0;
    drive(4'b0111); drive(4'b0000); drive(4'b0000); drive(4'b0111); idle_steps(8);
    check("dead_ignored_count", coinc_count, 1);
    drive(4'b0111); idle_steps(8);
    check("dead_pulses", phase_pulses, 2);
    check("dead_count", coinc_count, 2);

    // Dead time zero: two triples 3 cycles apart, never busy.
    set_cfg(4'b0111, 3, 2, 0);
    phase_pulses = 0; phase_busy = 0;
    drive(4'b0111); drive(4'b0000); drive(4'b0000); drive(4'b0111); idle_steps(5);
    check("dt0_pulses", phase_pulses, 2);
    check("dt0_busy_cycles", phase_busy, 0);

    // Mask and fold.
    set_cfg(4'b1011, 2, 0, 0);
    phase_pulses = 0;
    drive(4'b1100); idle_steps(4);
    check("mask_out_pulses", phase_pulses, 0);
    drive(4'b1010); idle_steps(4);
    check("mask_in_pulses", phase_pulses, 1);
    set_cfg(4'b1111, 0, 2, 0);
    phase_pulses = 0;
    drive(4'b1111); idle_steps(5);
    check("fold0_pulses", phase_pulses, 0);

    // Saturation after 17 coincidences.
    clear_counts();
    set_cfg(4'b0001, 1, 0, 0);
    for (int k = 0; k < 17; k++) begin
      drive(4'b0001); drive(4'b0000);
    end
    idle_steps(2);
    check("sat_count", coinc_count, CMAX);

    // Clear in the same cycle as a fire.
    drive(4'b0001);
    ch_in = '0; cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check("clr_fire_pulse", coinc_pulse, 1'b1);
    check("clr_fire_count", coinc_count, 0);
    idle_steps(2);

    // Asynchronous reset during DEAD, then input held high through release.
    set_cfg(4'b0111, 3, 2, 20);
    drive(4'b0111); drive(4'b0000); idle_steps(2);
    #2 rst = 1'b1;
    #1;
    check("arst_pulse", coinc_pulse, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_count", coinc_count, 0);
    model_reset();
    ch_in = 4'b1111;
    set_cfg(4'b1111, 4, 0, 0);
    #2 rst = 1'b0;
    phase_pulses = 0;
    for (int k = 0; k < 6; k++) step();
    check("held_high_pulses", phase_pulses, 1);
    idle_steps(2);

    // Randomized traffic with live configuration changes.
    for (int k = 0; k < 400; k++) begin
      ch_in     = N_CH'($urandom & $urandom);
      ch_mask   = N_CH'($urandom);
      min_fold  = FW'($urandom_range(0, N_CH));
      window    = WIN_W'($urandom_range(0, 3));
      dead_time = DT_W'($urandom_range(0, 6));
      cnt_clr   = ($urandom_range(0, 31) == 0);
      step();
    end
    cnt_clr = 1'b0;
    idle_steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
